// File: rtl/accum_sched_pkg.sv
// Shared helpers for the accumulation scheduler.
//   bw(n)         : bits needed to index n items (ceil(log2(n)), 0 for n <= 1)
//   sched_state_t : input-side group state (IDLE = no open group, OPEN = group started)
//   tag_t         : per-cycle tag travelling alongside the external adder tree
package GLOBAL_PARAM;

    function automatic int bw(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } sched_state_t;

    typedef struct packed {
        logic vld;
        logic last;
    } tag_t;

endpackage

// File: rtl/accum_sched_fifo.sv
// sched_fifo: small result FIFO holding {group sum, beat count} records.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (pointers/count only)
//   push_i    : write data_i this cycle (caller guarantees space)
//   data_i    : record to store
//   pop_i     : consumer ready; pops the head when valid_o is high
//   data_o    : head record, zero when empty
//   valid_o   : FIFO holds at least one record
module sched_fifo
    import GLOBAL_PARAM::*;
#(
    parameter int W     = 48,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         valid_o
);
    localparam int PW = (bw(DEPTH) < 1) ? 1 : bw(DEPTH);
    localparam int CW = bw(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid_o = (count_q != '0);
    assign do_pop  = pop_i && valid_o;
    assign data_o  = valid_o ? mem[rd_ptr_q] : '0;

    always_comb begin
        count_d = count_q;
        if (push_i && !do_pop)      count_d = count_q + 1'b1;
        else if (!push_i && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
            count_q <= count_d;
        end
    end

    // Storage carries data only; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_i) mem[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/accum_sched.sv
// accum_sched: feeds operand vectors to an external adder tree, accumulates
// the per-beat tree sums into group totals and hands them out through a
// small result FIFO.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_vec/in_valid/in_ready/in_last : input beats, in_last closes a group
//   tree_vec             : vector to the adder tree (zero when no beat accepted)
//   tree_sum             : signed tree result, LAT cycles after tree_vec
//   out_sum/out_beats/out_valid/out_ready : group total, beat count, handshake
module accum_sched
    import GLOBAL_PARAM::*;
#(
    parameter int DATA_W    = 16,
    parameter int DATA_N    = 32,
    parameter int RES_W     = bw(DATA_N) + DATA_W,
    parameter int ACC_W     = 32,
    parameter int LAT       = bw(DATA_N) + 1,
    parameter int OUT_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_N*DATA_W-1:0] in_vec,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    output logic [DATA_N*DATA_W-1:0] tree_vec,
    input  logic signed [RES_W-1:0]  tree_sum,
    output logic signed [ACC_W-1:0]  out_sum,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_beats
);
    localparam int PEND_W = bw(OUT_DEPTH + 1) + 1;

    sched_state_t            state_q, state_d;
    logic [PEND_W-1:0]       pending_q, pending_d;
    logic                    in_ready_q, in_ready_d;
    tag_t                    tag_q [LAT];
    tag_t                    tag_exit;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    first_q;
    logic                    accept, group_open, pop, push;

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Gating with rst keeps tree_vec quiet while reset is held.
    assign accept     = in_valid && in_ready_q && !rst;
    assign tree_vec   = accept ? in_vec : '0;
    assign in_ready   = in_ready_q;
    assign group_open = accept && (state_q == IDLE);
    assign pop        = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        if (accept) state_d = in_last ? IDLE : OPEN;
        pending_d = pending_q;
        if (group_open && !pop)      pending_d = pending_q + 1'b1;
        else if (!group_open && pop) pending_d = pending_q - 1'b1;
        // Admitting a new group only while a result slot is reserved for it
        // is what keeps the FIFO from overflowing without stalling the tree.
        in_ready_d = (state_d == OPEN) || (pending_d < PEND_W'(OUT_DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Tag pipeline: slot LAT-1 lines up with tree_sum for the same beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
        end else begin
            tag_q[0] <= '{vld: accept, last: accept && in_last};
            for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    assign tag_exit = tag_q[LAT-1];
    assign push     = tag_exit.vld && tag_exit.last;

    // Accumulate stage: first beat of a group restarts the running total.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (tag_exit.vld) begin
            acc_d = ACC_W'(tree_sum) + (first_q ? ACC_W'(0) : acc_q);
            cnt_d = first_q ? 16'd1 : sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            first_q <= 1'b1;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (push)              first_q <= 1'b1;
            else if (tag_exit.vld) first_q <= 1'b0;
        end
    end

    logic [ACC_W+15:0] fifo_dout;

    sched_fifo #(
        .W     (ACC_W + 16),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  ({acc_d, cnt_d}),
        .pop_i   (out_ready),
        .data_o  (fifo_dout),
        .valid_o (out_valid)
    );

    assign out_sum   = fifo_dout[ACC_W+15:16];
    assign out_beats = fifo_dout[15:0];

endmodule

// File: doc/accum_sched.md
ACCUM_SCHED -- requirements
Module: accum_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning input element width.
REQ-002 SHALL have parameter DATA_N, default 32, meaning elements per vector (power of 2).
REQ-003 SHALL have parameter RES_W, default bw(DATA_N)+DATA_W, meaning tree sum width.
REQ-004 SHALL have parameter ACC_W, default 32, meaning group accumulator width (ACC_W >= RES_W).
REQ-005 SHALL have parameter LAT, default bw(DATA_N)+1, meaning tree vec-to-sum latency in cycles.
REQ-006 SHALL have parameter OUT_DEPTH, default 2, meaning result buffer entries (>= 1).
REQ-007 clk  in  1  sole clock; all state on rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 in_vec  in  DATA_N*DATA_W  operand vector, packed, element i at [i*DATA_W +: DATA_W].
REQ-010 in_valid / in_ready  in / out  1  input beat handshake.
REQ-011 in_last  in  1  beat closes the current accumulation group.
REQ-012 tree_vec  out  DATA_N*DATA_W  vector driven to the adder tree.
REQ-013 tree_sum  in  RES_W  signed tree result, valid LAT cycles after tree_vec.
REQ-014 out_sum  out  ACC_W  signed group total.
REQ-015 out_valid / out_ready  out / in  1  result handshake.
REQ-016 out_beats  out  16  number of beats in the reported group.

Function
REQ-017 A beat SHALL be accepted on in_valid && in_ready; tree_vec SHALL equal in_vec on accepted beats and all-zero otherwise.
REQ-018 A LAT-deep tag pipeline SHALL carry {valid, last} per cycle, aligned so that the tag exits exactly when tree_sum for that beat is present.
REQ-019 On an exiting valid tag, acc SHALL become sign_ext(tree_sum) + (first-of-group ? 0 : acc); arithmetic is modulo 2^ACC_W, no saturation.
REQ-020 On an exiting tag with last=1, {acc_next, beat_cnt_next} SHALL be written into the result FIFO in the same cycle, and the accumulator SHALL be marked first-of-group for the next beat.
REQ-021 Input FSM SHALL have states IDLE (no open group) and OPEN (group started, last not yet accepted): IDLE->OPEN on accepted beat with in_last=0; OPEN->IDLE on accepted beat with in_last=1; an IDLE beat with in_last=1 is a single-beat group and stays in IDLE.
REQ-022 A counter `pending` SHALL count groups opened at the input but not yet popped from the result FIFO; it increments on the first accepted beat of a group and decrements on an out handshake, both in the same cycle giving net zero.
REQ-023 in_ready SHALL be 1 in OPEN, and in IDLE SHALL be 1 only when pending < OUT_DEPTH; the FIFO therefore never overflows and the tree never stalls.
REQ-024 out_valid SHALL be 1 when the FIFO is non-empty; out_sum/out_beats SHALL hold stable while out_valid && !out_ready.
REQ-025 Latency from accepting a last beat to out_valid SHALL be LAT+1 cycles when the FIFO is empty.
REQ-026 FIFO push and pop in the same cycle SHALL both take effect; read and write pointers wrap modulo OUT_DEPTH.
REQ-027 beat_cnt SHALL saturate at 16'hFFFF; acc continues to wrap.

Reset
REQ-028 Reset SHALL clear the tag pipeline, acc, beat_cnt, pending and FIFO pointers, and return the FSM to IDLE; partial groups in flight are discarded.
REQ-029 During and after reset: out_valid=0, out_sum=0, out_beats=0, tree_vec=0, in_ready=1.

Structure
REQ-030 bw() SHALL come from GLOBAL_PARAM; a state enum typedef (IDLE, OPEN) SHALL be added to that package.
REQ-031 The result FIFO SHALL be one sub-module, sched_fifo (width ACC_W+16, depth OUT_DEPTH); the adder tree SHALL be instantiated by the parent, not inside accum_sched.

Verification
REQ-032 3-beat group, all elements 1, DATA_N=32 -> one result, out_sum=96, out_beats=3, out_valid at LAT+1 after the last beat.
REQ-033 Single beat with in_last=1, elements alternating +5/-3 -> out_sum=32, out_beats=1.
REQ-034 out_ready=0, 3 single-beat groups -> in_ready drops after 2 groups are accepted; it rises the cycle after the first pop, and results are returned in order.
REQ-035 All elements 0x7FFF for 3 beats with ACC_W=RES_W=21 -> out_sum equals the true total (3145632) modulo 2^21, interpreted as signed.
REQ-036 Assert rst for one cycle mid-group (2 beats in flight) -> no result emitted, pending=0, and the next group reports only its own beats.
